// File: rtl/divisor_algoritmico_mc_if.sv
// Handshake and operand/result bundle for divisor_algoritmico_mc.
// master: the requester that drives operands and Start.
// slave: the divider that returns quotient, remainder and status.
interface divisor_algoritmico_mc_if #(
  parameter int tamanyo = 32
);
  logic               Start;
  logic               Signed_mode;
  logic [tamanyo-1:0] Num;
  logic [tamanyo-1:0] Den;
  logic [tamanyo-1:0] Coc;
  logic [tamanyo-1:0] Res;
  logic               Done;
  logic               Busy;
  logic               Dbz;

  modport master (
    output Start, Signed_mode, Num, Den,
    input  Coc, Res, Done, Busy, Dbz
  );

  modport slave (
    input  Start, Signed_mode, Num, Den,
    output Coc, Res, Done, Busy, Dbz
  );
endinterface

// File: rtl/divisor_algoritmico_mc.sv
// divisor_algoritmico_mc: multicycle restoring divider, one quotient bit per
// clock, signed or unsigned operands selected at Start.
// Latency is tamanyo+2 cycles from the Start sampling edge to the Done cycle.
// Optional macro DIVISOR_DBZ_DETECT_EN: a zero divisor bypasses the loop,
// raises Dbz and returns Coc = all ones, Res = Num two cycles after Start.
module divisor_algoritmico_mc #(
  parameter int tamanyo = 32
) (
  input logic                     CLK,
  input logic                     RSTa,
  divisor_algoritmico_mc_if.slave bus
);

  localparam int CW = $clog2(tamanyo);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOOP = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;

  // Datapath registers; they carry no reset because every operation
  // reloads them at capture before they are used.
  logic [tamanyo-1:0] rem;
  logic [tamanyo-1:0] quo;
  logic [tamanyo-1:0] den_mag;
  logic               sq;
  logic               sr;
`ifdef DIVISOR_DBZ_DETECT_EN
  logic               dbz_pend;
  logic               den_zero;
`endif

  logic               s_num;
  logic               s_den;
  logic [tamanyo-1:0] num_abs;
  logic [tamanyo-1:0] den_abs;
  logic [tamanyo:0]   rem_sh;
  logic               fits;
  logic [tamanyo-1:0] diff;

  // Two's-complement negate when sel is set; -(-2^(n-1)) wraps back to
  // 2^(n-1), which is the correct unsigned magnitude in n bits.
  function automatic logic [tamanyo-1:0] neg_if(input logic sel,
                                                input logic [tamanyo-1:0] v);
    return sel ? (~v + 1'b1) : v;
  endfunction

  // Operand magnitudes at capture and one restoring step of the loop.
  // The n+1-bit partial remainder only exists as rem_sh; once the trial
  // subtraction is resolved the kept remainder is below |Den| and fits n bits.
  always_comb begin
    s_num   = bus.Signed_mode & bus.Num[tamanyo-1];
    s_den   = bus.Signed_mode & bus.Den[tamanyo-1];
    num_abs = neg_if(s_num, bus.Num);
    den_abs = neg_if(s_den, bus.Den);
    rem_sh  = {rem, quo[tamanyo-1]};
    fits    = (rem_sh >= {1'b0, den_mag});
    diff    = rem_sh[tamanyo-1:0] - den_mag;
`ifdef DIVISOR_DBZ_DETECT_EN
    den_zero = (bus.Den == '0);
`endif
  end

  // Load magnitudes and signs at capture, then shift/subtract once per LOOP cycle.
  always_ff @(posedge CLK) begin
    if (state == IDLE && bus.Start) begin
      rem     <= '0;
      quo     <= num_abs;
      den_mag <= den_abs;
      sq      <= s_num ^ s_den;
      sr      <= s_num;
`ifdef DIVISOR_DBZ_DETECT_EN
      dbz_pend <= den_zero;
`endif
    end else if (state == LOOP) begin
      rem <= fits ? diff : rem_sh[tamanyo-1:0];
      quo <= {quo[tamanyo-2:0], fits};
    end
  end

  // Sequencing FSM and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      state    <= IDLE;
      cnt      <= '0;
      bus.Coc  <= '0;
      bus.Res  <= '0;
      bus.Done <= 1'b0;
      bus.Busy <= 1'b0;
      bus.Dbz  <= 1'b0;
    end else begin
      bus.Done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.Start) begin
            bus.Busy <= 1'b1;
            cnt      <= CW'(tamanyo - 1);
`ifdef DIVISOR_DBZ_DETECT_EN
            state    <= den_zero ? FIX : LOOP;
`else
            state    <= LOOP;
`endif
          end
        end
        LOOP: begin
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          bus.Done <= 1'b1;
          bus.Busy <= 1'b0;
          state    <= IDLE;
`ifdef DIVISOR_DBZ_DETECT_EN
          if (dbz_pend) begin
            // quo still holds |Num|; re-applying the dividend sign restores raw Num.
            bus.Coc <= '1;
            bus.Res <= neg_if(sr, quo);
            bus.Dbz <= 1'b1;
          end else begin
            bus.Coc <= neg_if(sq, quo);
            bus.Res <= neg_if(sr, rem);
            bus.Dbz <= 1'b0;
          end
`else
          bus.Coc <= neg_if(sq, quo);
          bus.Res <= neg_if(sr, rem);
          bus.Dbz <= 1'b0;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_algoritmico_mc.sv
// Directed testbench for divisor_algoritmico_mc at tamanyo = 8.
// Expected divide-by-zero behaviour follows DIVISOR_DBZ_DETECT_EN.
module tb_divisor_algoritmico_mc;

  localparam int N = 8;

  logic CLK  = 1'b0;
  logic RSTa = 1'b0;
  int   checks = 0;
  int   errors = 0;

  divisor_algoritmico_mc_if #(.tamanyo(N)) bus ();

  divisor_algoritmico_mc #(.tamanyo(N)) dut (
    .CLK  (CLK),
    .RSTa (RSTa),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       sm;
    logic [7:0] num;
    logic [7:0] den;
    logic [7:0] coc;
    logic [7:0] res;
    logic       dbz;
    int         lat;
  } vec_t;

  vec_t vt[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Issue one division and check latency, results, Done width and result hold.
  task automatic run_div(input string name, input logic sm, input logic [7:0] n,
                         input logic [7:0] d, input logic [7:0] ec, input logic [7:0] er,
                         input logic edbz, input int elat);
    int lat;
    logic [7:0] c0, r0;
    @(negedge CLK);
    bus.Start = 1'b1; bus.Signed_mode = sm; bus.Num = n; bus.Den = d;
    @(posedge CLK); #1;
    chk({name, "_busy"}, 32'(bus.Busy), 32'd1);
    @(negedge CLK);
    bus.Start = 1'b0;
    lat = 0;
    do begin
      @(posedge CLK); #1;
      lat++;
    end while (!bus.Done && lat < 40);
    chk({name, "_lat"}, 32'(lat), 32'(elat));
    chk({name, "_coc"}, 32'(bus.Coc), 32'(ec));
    chk({name, "_res"}, 32'(bus.Res), 32'(er));
    chk({name, "_dbz"}, 32'(bus.Dbz), 32'(edbz));
    c0 = bus.Coc; r0 = bus.Res;
    @(posedge CLK); #1;
    chk({name, "_done_w"}, {bus.Done, bus.Busy}, 32'd0);
    chk({name, "_hold"}, {bus.Coc, bus.Res}, {c0, r0});
  endtask

  initial begin
    int lat, t1, t2, ndone;
    logic sm;
    logic [7:0] n, d, ec, er;
    logic signed [7:0] sn, sd;

    vt[0]  = '{1'b0, 8'd100, 8'd7,   8'd14,  8'd2,   1'b0, N + 1};
    vt[1]  = '{1'b1, 8'hF9,  8'h02,  8'hFD,  8'hFF,  1'b0, N + 1};
    vt[2]  = '{1'b1, 8'h07,  8'hFE,  8'hFD,  8'h01,  1'b0, N + 1};
    vt[3]  = '{1'b1, 8'h80,  8'hFF,  8'h80,  8'h00,  1'b0, N + 1};
    vt[4]  = '{1'b0, 8'd255, 8'd1,   8'd255, 8'd0,   1'b0, N + 1};
    vt[5]  = '{1'b0, 8'd5,   8'd9,   8'd0,   8'd5,   1'b0, N + 1};
    vt[6]  = '{1'b1, 8'h80,  8'h07,  8'hEE,  8'hFE,  1'b0, N + 1};
    vt[7]  = '{1'b0, 8'h80,  8'hFF,  8'h00,  8'h80,  1'b0, N + 1};
    vt[8]  = '{1'b0, 8'd200, 8'd200, 8'd1,   8'd0,   1'b0, N + 1};
`ifdef DIVISOR_DBZ_DETECT_EN
    vt[9]  = '{1'b0, 8'h5A,  8'h00,  8'hFF,  8'h5A,  1'b1, 1};
    vt[10] = '{1'b1, 8'hFD,  8'h00,  8'hFF,  8'hFD,  1'b1, 1};
`else
    vt[9]  = '{1'b0, 8'h5A,  8'h00,  8'hFF,  8'h5A,  1'b0, N + 1};
    vt[10] = '{1'b1, 8'hFD,  8'h00,  8'h01,  8'hFD,  1'b0, N + 1};
`endif

    bus.Start = 1'b0; bus.Signed_mode = 1'b0; bus.Num = '0; bus.Den = '0;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outs", {bus.Coc, bus.Res, bus.Done, bus.Busy, bus.Dbz}, 32'd0);
    @(negedge CLK);
    RSTa = 1'b1;

    // Directed table
    foreach (vt[i])
      run_div($sformatf("vec%0d", i), vt[i].sm, vt[i].num, vt[i].den,
              vt[i].coc, vt[i].res, vt[i].dbz, vt[i].lat);

    // Start re-pulsed with new operands during LOOP is ignored
    @(negedge CLK);
    bus.Start = 1'b1; bus.Signed_mode = 1'b0; bus.Num = 8'd100; bus.Den = 8'd7;
    @(posedge CLK); #1;
    lat = 0;
    do begin
      @(negedge CLK);
      bus.Start = (lat == 3);
      if (lat == 3) begin bus.Num = 8'd50; bus.Den = 8'd3; end
      @(posedge CLK); #1;
      lat++;
    end while (!bus.Done && lat < 40);
    chk("repulse_lat", 32'(lat), 32'(N + 1));
    chk("repulse_res", {bus.Coc, bus.Res}, {8'd14, 8'd2});
    @(negedge CLK);
    bus.Start = 1'b0;
    repeat (2) @(posedge CLK);

    // Start held high: consecutive Done pulses tamanyo+2 cycles apart
    @(negedge CLK);
    bus.Start = 1'b1; bus.Signed_mode = 1'b0; bus.Num = 8'd100; bus.Den = 8'd7;
    @(posedge CLK); #1;
    lat = 0; t1 = -1; t2 = -1; ndone = 0;
    do begin
      @(posedge CLK); #1;
      lat++;
      if (bus.Done) begin
        ndone++;
        if (t1 < 0) t1 = lat; else t2 = lat;
      end
    end while (ndone < 2 && lat < 60);
    @(negedge CLK);
    bus.Start = 1'b0;
    chk("held_first", 32'(t1), 32'(N + 1));
    chk("held_gap", 32'(t2 - t1), 32'(N + 2));
    repeat (2) @(posedge CLK);

    // Reset asserted mid-LOOP clears outputs at once and suppresses Done
    @(negedge CLK);
    bus.Start = 1'b1; bus.Signed_mode = 1'b0; bus.Num = 8'd77; bus.Den = 8'd5;
    @(posedge CLK); #1;
    @(negedge CLK);
    bus.Start = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    RSTa = 1'b0;
    #1;
    chk("rst_mid_outs", {bus.Coc, bus.Res, bus.Done, bus.Busy, bus.Dbz}, 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RSTa = 1'b1;
    ndone = 0;
    repeat (N + 6) begin
      @(posedge CLK); #1;
      if (bus.Done || bus.Busy) ndone++;
    end
    chk("rst_no_done", 32'(ndone), 32'd0);
    run_div("after_rst", 1'b0, 8'd77, 8'd5, 8'd15, 8'd2, 1'b0, N + 1);

    // Regression against the language's own / and % operators
    for (int k = 0; k < 150; k++) begin
      sm = 1'($urandom_range(0, 1));
      n  = 8'($urandom);
      d  = 8'($urandom_range(1, 255));
      if (sm) begin
        sn = $signed(n); sd = $signed(d);
        ec = 8'(sn / sd);
        er = 8'(sn % sd);
      end else begin
        ec = n / d;
        er = n % d;
      end
      run_div($sformatf("rnd%0d", k), sm, n, d, ec, er, 1'b0, N + 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
